// File: rtl/qam_dsp_pkg.sv
// Shared constants, FSM state encoding and the round/saturate helper for the
// QAM receive DSP chain.
//
// Contents:
//   DATA_W / COEF_W / ACC_W / OUT_W      datapath widths
//   NTAPS / ADDR_W / SHIFT / FIFO_D      filter length, shift, FIFO depth
//   RATE_W                               decimation-rate port width
//   mac_state_t                          MAC sequencer states
//   round_sat()                          acc -> OUT_W sample, round half up
package qam_dsp_pkg;

    localparam int DATA_W = 10;
    localparam int COEF_W = 8;
    localparam int NTAPS  = 64;
    localparam int ADDR_W = $clog2(NTAPS);
    localparam int ACC_W  = 24;
    localparam int SHIFT  = 7;
    localparam int OUT_W  = 12;
    localparam int FIFO_D = 4;
    localparam int RATE_W = 9;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(2 ** (OUT_W - 1) - 1);
    // Bitwise inverse of the positive limit is exactly the negative limit.
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_PUSH  = 2'd3
    } mac_state_t;

    // Round half up by adding half an LSB before the arithmetic shift, then
    // clamp to the signed output range.
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic signed [OUT_W-1:0] res;
        shifted = (acc + ROUND_BIAS) >>> SHIFT;
        if (shifted > SAT_MAX) begin
            res = OUT_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            res = OUT_W'(SAT_MIN);
        end else begin
            res = OUT_W'(shifted);
        end
        return res;
    endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO (also used on the TX side).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   push, push_data     write request and data; accepted when not full, or
//                       when full but a pop happens in the same cycle
//   full                no free slot
//   pop                 consume head; ignored when empty
//   pop_data            current head word (valid while !empty)
//   empty               no stored words
module dsp_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Qualify pop/push; a pop on a full FIFO frees the slot the push reuses.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/downsamp_decimator.sv
// Receive decimating FIR: NTAPS-tap runtime-loadable filter evaluated by a
// single serial MAC, decimation by decim_rate, results queued in a FWFT FIFO.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   adc_data, adc_valid            signed ADC sample stream, no backpressure
//   decim_rate                     decimation factor (0 behaves as 1)
//   addr, coefficient, write_en    coefficient load port (IDLE only)
//   out_data, out_valid, out_ready FIFO head with valid/ready handshake
//   busy                           MAC sequencer not idle
//   overrun, overflow, cfg_err     sticky error flags, cleared only by rst
module downsamp_decimator
    import qam_dsp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] adc_data,
    input  logic                     adc_valid,
    input  logic [RATE_W-1:0]        decim_rate,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [COEF_W-1:0] coefficient,
    input  logic                     write_en,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     overrun,
    output logic                     overflow,
    output logic                     cfg_err
);

    logic signed [DATA_W-1:0] taps_r [NTAPS];
    logic signed [DATA_W-1:0] snap_r [NTAPS];
    logic signed [COEF_W-1:0] coef_r [NTAPS];
    logic [RATE_W-1:0]        cnt_r;
    mac_state_t               state_r;
    mac_state_t               state_nxt_s;
    logic [ADDR_W-1:0]        idx_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [OUT_W-1:0]  result_r;
    logic signed [PROD_W-1:0] prod_s;
    logic [RATE_W-1:0]        eff_rate_s;
    logic                     trigger_s;
    logic                     idle_s;
    logic                     fifo_push_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;

    // Decimation trigger. The >= compare lets a rate lowered mid-run wrap on
    // the next valid sample instead of waiting for the counter to roll over.
    always_comb begin
        eff_rate_s  = (decim_rate == {RATE_W{1'b0}}) ? {{(RATE_W-1){1'b0}}, 1'b1} : decim_rate;
        trigger_s   = adc_valid && (cnt_r >= (eff_rate_s - {{(RATE_W-1){1'b0}}, 1'b1}));
        idle_s      = (state_r == ST_IDLE);
        fifo_push_s = (state_r == ST_PUSH);
        prod_s      = snap_r[idx_r] * coef_r[idx_r];
    end

    // Sample delay line and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {RATE_W{1'b0}};
            for (int k = 0; k < NTAPS; k++) begin
                taps_r[k] <= {DATA_W{1'b0}};
            end
        end else if (adc_valid) begin
            taps_r[0] <= adc_data;
            for (int k = 1; k < NTAPS; k++) begin
                taps_r[k] <= taps_r[k-1];
            end
            if (trigger_s) begin
                cnt_r <= {RATE_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(RATE_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Snapshot includes the sample arriving in the trigger cycle; coefficient
    // writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                snap_r[k] <= {DATA_W{1'b0}};
                coef_r[k] <= {COEF_W{1'b0}};
            end
        end else begin
            if (idle_s && trigger_s) begin
                snap_r[0] <= adc_data;
                for (int k = 1; k < NTAPS; k++) begin
                    snap_r[k] <= taps_r[k-1];
                end
            end
            if (idle_s && write_en) begin
                coef_r[addr] <= coefficient;
            end
        end
    end

    // MAC sequencer next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_nxt_s = ST_MAC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (idx_r == ADDR_W'(NTAPS - 1)) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_MAC;
                end
            end
            ST_ROUND: state_nxt_s = ST_PUSH;
            ST_PUSH:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; busy tracks the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Accumulator, tap index and rounded result. The accumulator is cleared
    // every idle cycle so it starts from zero on entry to MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {ACC_W{1'b0}};
            idx_r    <= {ADDR_W{1'b0}};
            result_r <= {OUT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    acc_r <= {ACC_W{1'b0}};
                    idx_r <= {ADDR_W{1'b0}};
                end
                ST_MAC: begin
                    acc_r <= acc_r + ACC_W'(prod_s);
                    idx_r <= idx_r + ADDR_W'(1);
                end
                ST_ROUND: result_r <= round_sat(acc_r);
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Sticky error flags. A push into a full FIFO still succeeds when the
    // consumer pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            overflow <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            overrun  <= overrun  | (trigger_s && !idle_s);
            cfg_err  <= cfg_err  | (write_en && !idle_s);
            overflow <= overflow | (fifo_push_s && fifo_full_s && !out_ready);
        end
    end

    dsp_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (result_r),
        .full      (fifo_full_s),
        .pop       (out_ready),
        .pop_data  (out_data),
        .empty     (fifo_empty_s)
    );

    assign out_valid = !fifo_empty_s;

endmodule
